// File: rtl/sysbus_pkg.sv
// Shared constants and types for the Sysbus memory responder: tag field encodings,
// line geometry and the responder state enum.
package sysbus_pkg;

    localparam logic       READ           = 1'b1;
    localparam logic       WRITE          = 1'b0;
    localparam logic [3:0] MEMORY         = 4'b0001;
    localparam logic [3:0] MMIO           = 4'b0011;
    localparam int         TAG_WIDTH      = 13;
    localparam int         BEATS_PER_LINE = 8;
    localparam int         BEAT_BITS      = 3;
    localparam int         LINE_OFS_BITS  = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_RWAIT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Tag layout is {rw, type[3:0], id[7:0]}.
    function automatic logic [3:0] tag_type(input logic [TAG_WIDTH-1:0] tag);
        return tag[11:8];
    endfunction

endpackage

// File: rtl/sysbus_mem_array.sv
// Beat-addressed line store: one combinational read port, one synchronous write port.
// Contents are not reset.
module sysbus_mem_array #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_BITS  = 13
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_BITS-1:0]  i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_BITS-1:0]  i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_BITS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory-side target: accepts one 64-byte line transaction at a time, absorbs
// 8 write beats or returns 8 read beats after READ_LATENCY cycles.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int TAG_WIDTH    = 13,
    parameter int DEPTH_LINES  = 1024,
    parameter int READ_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reqcyc,
    input  logic [DATA_WIDTH-1:0] req,
    input  logic [TAG_WIDTH-1:0]  reqtag,
    output logic                  reqack,
    output logic                  respcyc,
    output logic [DATA_WIDTH-1:0] resp,
    output logic [TAG_WIDTH-1:0]  resptag,
    input  logic                  respack,
    output logic [1:0]            o_dbg_state
);

    localparam int LINE_BITS = $clog2(DEPTH_LINES);
    localparam int LAT_BITS  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int ADDR_BITS = LINE_BITS + BEAT_BITS;

    // Handshake: a header is taken on any edge in IDLE with reqcyc=1 and answered by a
    // one-cycle reqack; write beats are taken on edges in WDATA with reqcyc=1; a read
    // beat is presented while respcyc=1 and retires on an edge with respack=1.

    state_t                r_state;
    state_t                w_next_state;
    logic [LINE_BITS-1:0]  r_line;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [BEAT_BITS-1:0]  r_cnt;
    logic [LAT_BITS-1:0]   r_lat;
    logic                  r_reqack;

    logic                  w_hdr;
    logic                  w_beat_done;
    logic                  w_is_mem;
    logic                  w_we;
    logic [ADDR_BITS-1:0]  w_addr;
    logic [DATA_WIDTH-1:0] w_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_hdr        = 1'b0;
        w_beat_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (reqcyc) begin
                    w_hdr        = 1'b1;
                    w_next_state = (reqtag[TAG_WIDTH-1] == READ) ? ST_RWAIT : ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (reqcyc) begin
                    w_beat_done = 1'b1;
                    if (r_cnt == 3'd7) w_next_state = ST_IDLE;
                end
            end
            ST_RWAIT: begin
                if (r_lat == '0) w_next_state = ST_RESP;
            end
            ST_RESP: begin
                if (respack) begin
                    w_beat_done = 1'b1;
                    if (r_cnt == 3'd7) w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line   <= '0;
            r_tag    <= '0;
            r_cnt    <= '0;
            r_lat    <= '0;
            r_reqack <= 1'b0;
        end else begin
            r_reqack <= w_hdr;
            if (w_hdr) begin
                r_line <= req[LINE_OFS_BITS +: LINE_BITS];
                r_tag  <= reqtag;
                r_cnt  <= '0;
                r_lat  <= LAT_BITS'(READ_LATENCY - 1);
            end else if (w_beat_done) begin
                r_cnt <= r_cnt + 3'd1;
            end
            if (r_state == ST_RWAIT && r_lat != '0) begin
                r_lat <= r_lat - 1'b1;
            end
        end
    end

    // Non-memory targets ack writes but never touch the array and read back zeros.
    assign w_is_mem = (tag_type(r_tag) == MEMORY);
    assign w_we     = (r_state == ST_WDATA) && reqcyc && w_is_mem;
    assign w_addr   = {r_line, r_cnt};

    sysbus_mem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .i_clk  (clk),
        .i_we   (w_we),
        .i_waddr(w_addr),
        .i_wdata(req),
        .i_raddr(w_addr),
        .o_rdata(w_rdata)
    );

    assign reqack      = r_reqack;
    assign respcyc     = (r_state == ST_RESP);
    assign resp        = (respcyc && w_is_mem) ? w_rdata : '0;
    assign resptag     = r_tag;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Self-checking bench for sysbus_mem_responder against a line-level memory model.
module tb_sysbus_mem_responder;

  localparam int DW = 64;
  localparam int TW = 13;
  localparam int DL = 1024;
  localparam int RL = 4;
  localparam logic [3:0] T_MEM  = 4'b0001;
  localparam logic [3:0] T_MMIO = 4'b0011;

  logic          clk = 1'b0;
  logic          reset;
  logic          reqcyc;
  logic [DW-1:0] req;
  logic [TW-1:0] reqtag;
  logic          reqack;
  logic          respcyc;
  logic [DW-1:0] resp;
  logic [TW-1:0] resptag;
  logic          respack;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [int];
  logic [DW-1:0] wr_data [8];
  logic          wr_ack;
  int            wr_spur;
  logic [DW-1:0] rd_beats [8];
  int            rd_n, rd_first, rd_stall_err, rd_tag_err, rd_spur_ack;
  logic          rd_ack, rd_tail_low, rd_timeout;

  sysbus_mem_responder #(
    .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH_LINES(DL), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset), .reqcyc(reqcyc), .req(req), .reqtag(reqtag),
    .reqack(reqack), .respcyc(respcyc), .resp(resp), .resptag(resptag),
    .respack(respack), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model
  function automatic int line_of(input logic [DW-1:0] addr);
    return int'((addr >> 6) % DL);
  endfunction

  function automatic logic [DW-1:0] exp_beat(input logic [DW-1:0] addr, input logic [TW-1:0] tag, input int b);
    int key;
    if (tag[11:8] != T_MEM) return '0;
    key = line_of(addr) * 8 + b;
    if (model_mem.exists(key)) return model_mem[key];
    return '0;
  endfunction

  function automatic logic [TW-1:0] mk_tag(input logic rw, input logic [3:0] ty);
    logic [7:0] id;
    id = 8'($urandom);
    return {rw, ty, id};
  endfunction

  // drivers
  task automatic do_write(input logic [DW-1:0] addr, input logic [TW-1:0] tag, input int gap_after, input int gap_n);
    wr_spur = 0;
    @(negedge clk);
    reqcyc = 1'b1; req = addr; reqtag = tag;
    @(negedge clk);
    wr_ack = (reqack === 1'b1);
    for (int b = 0; b < 8; b++) begin
      reqcyc = 1'b1; req = wr_data[b]; reqtag = TW'($urandom);
      @(negedge clk);
      if (reqack !== 1'b0) wr_spur++;
      if (b == gap_after) begin
        reqcyc = 1'b0; req = {$urandom, $urandom};
        repeat (gap_n) begin
          @(negedge clk);
          if (reqack !== 1'b0) wr_spur++;
        end
      end
    end
    reqcyc = 1'b0;
    if (tag[11:8] == T_MEM)
      for (int b = 0; b < 8; b++) model_mem[line_of(addr) * 8 + b] = wr_data[b];
  endtask

  task automatic do_read(input logic [DW-1:0] addr, input logic [TW-1:0] tag, input int stall_beat,
                         input int stall_n, input bit pulse, input int abort_after);
    int k;
    int stall_left;
    logic [DW-1:0] held;
    rd_n = 0; rd_first = -1; rd_stall_err = 0; rd_tag_err = 0; rd_spur_ack = 0;
    held = '0;
    @(negedge clk);
    reqcyc = 1'b1; req = addr; reqtag = tag; respack = 1'b0;
    @(negedge clk);
    reqcyc = 1'b0;
    rd_ack = (reqack === 1'b1);
    k = 0;
    stall_left = stall_n;
    while (rd_n < abort_after && k < 200) begin
      if (k > 0 && reqack !== 1'b0) rd_spur_ack++;
      if (respcyc === 1'b1) begin
        if (rd_first < 0) rd_first = k;
        if (resptag !== tag) rd_tag_err++;
        if (rd_n == stall_beat && stall_left > 0) begin
          if (stall_left == stall_n) held = resp;
          else if (resp !== held) rd_stall_err++;
          stall_left--;
          respack = 1'b0;
        end else begin
          if (rd_n == stall_beat && stall_n > 0 && resp !== held) rd_stall_err++;
          rd_beats[rd_n] = resp;
          rd_n++;
          respack = 1'b1;
        end
        if (pulse) begin
          reqcyc = 1'($urandom_range(0, 1)); req = {$urandom, $urandom}; reqtag = TW'($urandom);
        end
      end else begin
        respack = 1'b0; reqcyc = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    reqcyc = 1'b0; respack = 1'b0;
    rd_timeout = (rd_n < abort_after);
    rd_tail_low = (respcyc === 1'b0) && (reqack === 1'b0);
  endtask

  // tests
  task automatic test_reset;
    reset = 1'b1; reqcyc = 1'b0; req = '0; reqtag = '0; respack = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (reqack !== 1'b0) begin errors++; $display("FAIL reset_reqack got=%b exp=0", reqack); end
    checks++; if (respcyc !== 1'b0) begin errors++; $display("FAIL reset_respcyc got=%b exp=0", respcyc); end
    checks++; if (resp !== '0) begin errors++; $display("FAIL reset_resp got=%h exp=0", resp); end
    checks++; if (resptag !== '0) begin errors++; $display("FAIL reset_resptag got=%h exp=0", resptag); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    logic [TW-1:0] tag;
    for (int b = 0; b < 8; b++) wr_data[b] = DW'((b + 1) * 8'h11);
    do_write(64'h140, mk_tag(1'b0, T_MEM), -1, 0);
    checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL wr_reqack got=%b exp=1", wr_ack); end
    checks++; if (wr_spur != 0) begin errors++; $display("FAIL wr_extra_ack got=%0d exp=0", wr_spur); end
    tag = mk_tag(1'b1, T_MEM);
    do_read(64'h140, tag, -1, 0, 1'b0, 8);
    checks++; if (rd_ack !== 1'b1) begin errors++; $display("FAIL rd_reqack got=%b exp=1", rd_ack); end
    checks++; if (rd_first != RL) begin errors++; $display("FAIL rd_latency got=%0d exp=%0d", rd_first, RL); end
    checks++; if (rd_timeout) begin errors++; $display("FAIL rd_timeout beats=%0d exp=8", rd_n); end
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (rd_beats[b] !== DW'((b + 1) * 8'h11)) begin
        errors++; $display("FAIL rd_beat%0d got=%h exp=%h", b, rd_beats[b], DW'((b + 1) * 8'h11));
      end
    end
    checks++; if (rd_tag_err != 0) begin errors++; $display("FAIL rd_resptag errs=%0d exp=0", rd_tag_err); end
    checks++; if (rd_tail_low !== 1'b1) begin errors++; $display("FAIL rd_tail respcyc=%b exp=0", respcyc); end
  endtask

  task automatic test_offset_alias;
    logic [DW-1:0] addrs [2];
    logic [TW-1:0] tag;
    addrs[0] = 64'h147;
    addrs[1] = 64'h140 + DL * 64;
    for (int a = 0; a < 2; a++) begin
      tag = mk_tag(1'b1, T_MEM);
      do_read(addrs[a], tag, -1, 0, 1'b0, 8);
      checks++; if (rd_timeout) begin errors++; $display("FAIL alias%0d_timeout beats=%0d exp=8", a, rd_n); end
      for (int b = 0; b < 8; b++) begin
        checks++;
        if (rd_beats[b] !== exp_beat(64'h140, tag, b)) begin
          errors++; $display("FAIL alias%0d_beat%0d got=%h exp=%h", a, b, rd_beats[b], exp_beat(64'h140, tag, b));
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [TW-1:0] tag;
    tag = mk_tag(1'b1, T_MEM);
    do_read(64'h140, tag, 2, 3, 1'b0, 8);
    checks++; if (rd_stall_err != 0) begin errors++; $display("FAIL stall_stable errs=%0d exp=0", rd_stall_err); end
    checks++; if (rd_n != 8) begin errors++; $display("FAIL stall_count got=%0d exp=8", rd_n); end
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (rd_beats[b] !== exp_beat(64'h140, tag, b)) begin
        errors++; $display("FAIL stall_beat%0d got=%h exp=%h", b, rd_beats[b], exp_beat(64'h140, tag, b));
      end
    end
    checks++; if (rd_tail_low !== 1'b1) begin errors++; $display("FAIL stall_tail respcyc=%b exp=0", respcyc); end
  endtask

  task automatic test_gaps_and_pulses;
    logic [DW-1:0] addr;
    logic [TW-1:0] tag;
    addr = 64'h3C0;
    for (int b = 0; b < 8; b++) wr_data[b] = {$urandom, $urandom};
    do_write(addr, mk_tag(1'b0, T_MEM), 3, 2);
    checks++; if (wr_spur != 0) begin errors++; $display("FAIL gap_extra_ack got=%0d exp=0", wr_spur); end
    tag = mk_tag(1'b1, T_MEM);
    do_read(addr, tag, -1, 0, 1'b1, 8);
    checks++; if (rd_spur_ack != 0) begin errors++; $display("FAIL pulse_extra_ack got=%0d exp=0", rd_spur_ack); end
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (rd_beats[b] !== exp_beat(addr, tag, b)) begin
        errors++; $display("FAIL gap_beat%0d got=%h exp=%h", b, rd_beats[b], exp_beat(addr, tag, b));
      end
    end
    checks++; if (rd_tail_low !== 1'b1) begin errors++; $display("FAIL pulse_tail respcyc=%b reqack=%b exp=0", respcyc, reqack); end
  endtask

  task automatic test_reset_mid_resp;
    logic [TW-1:0] tag;
    tag = mk_tag(1'b1, T_MEM);
    do_read(64'h140, tag, -1, 0, 1'b0, 5);
    checks++; if (respcyc !== 1'b1) begin errors++; $display("FAIL midrst_pre respcyc=%b exp=1", respcyc); end
    #2 reset = 1'b1;
    #1;
    checks++; if (respcyc !== 1'b0) begin errors++; $display("FAIL midrst_respcyc got=%b exp=0", respcyc); end
    checks++; if (reqack !== 1'b0) begin errors++; $display("FAIL midrst_reqack got=%b exp=0", reqack); end
    checks++; if (resp !== '0) begin errors++; $display("FAIL midrst_resp got=%h exp=0", resp); end
    @(negedge clk);
    reset = 1'b0;
    tag = mk_tag(1'b1, T_MEM);
    do_read(64'h140, tag, -1, 0, 1'b0, 8);
    checks++; if (rd_n != 8) begin errors++; $display("FAIL midrst_count got=%0d exp=8", rd_n); end
    checks++; if (rd_first != RL) begin errors++; $display("FAIL midrst_latency got=%0d exp=%0d", rd_first, RL); end
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (rd_beats[b] !== exp_beat(64'h140, tag, b)) begin
        errors++; $display("FAIL midrst_beat%0d got=%h exp=%h", b, rd_beats[b], exp_beat(64'h140, tag, b));
      end
    end
  endtask

  task automatic test_mmio;
    logic [TW-1:0] tag;
    tag = mk_tag(1'b1, T_MMIO);
    do_read(64'h140, tag, -1, 0, 1'b0, 8);
    checks++; if (rd_ack !== 1'b1) begin errors++; $display("FAIL mmio_rd_ack got=%b exp=1", rd_ack); end
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (rd_beats[b] !== '0) begin errors++; $display("FAIL mmio_rd_beat%0d got=%h exp=0", b, rd_beats[b]); end
    end
    for (int b = 0; b < 8; b++) wr_data[b] = {$urandom, $urandom};
    do_write(64'h140, mk_tag(1'b0, T_MMIO), -1, 0);
    checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL mmio_wr_ack got=%b exp=1", wr_ack); end
    tag = mk_tag(1'b1, T_MEM);
    do_read(64'h140, tag, -1, 0, 1'b0, 8);
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (rd_beats[b] !== exp_beat(64'h140, tag, b)) begin
        errors++; $display("FAIL mmio_wr_beat%0d got=%h exp=%h", b, rd_beats[b], exp_beat(64'h140, tag, b));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] lines [4];
    logic [DW-1:0] addr;
    logic [TW-1:0] tag;
    for (int i = 0; i < 4; i++) lines[i] = DW'($urandom_range(0, 4 * DL - 1)) << 6;
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 8; b++) wr_data[b] = {$urandom, $urandom};
      do_write(lines[i] | DW'($urandom_range(0, 63)), mk_tag(1'b0, T_MEM),
               $urandom_range(0, 7), $urandom_range(0, 3));
    end
    for (int n = 0; n < 6; n++) begin
      addr = lines[$urandom_range(0, 3)] | DW'($urandom_range(0, 63));
      tag = mk_tag(1'b1, T_MEM);
      do_read(addr, tag, $urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 8);
      checks++; if (rd_first != RL) begin errors++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", n, rd_first, RL); end
      for (int b = 0; b < 8; b++) begin
        checks++;
        if (rd_beats[b] !== exp_beat(addr, tag, b)) begin
          errors++; $display("FAIL b2b%0d_beat%0d got=%h exp=%h", n, b, rd_beats[b], exp_beat(addr, tag, b));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_offset_alias();
    test_backpressure();
    test_gaps_and_pulses();
    test_reset_mid_resp();
    test_mmio();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
